// File: rtl/ofifo_collect.sv
// Output FIFO collector: one circular queue per array column, popped a whole row at a time.
// Writes are per column; a row read pops every column together and registers the row on out.
module ofifo_collect #(
  parameter int COL   = 8,
  parameter int BW    = 16,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [COL*BW-1:0] in,
  input  logic [COL-1:0]   wr,
  input  logic             rd,
  output logic [COL*BW-1:0] out,
  output logic             o_valid,
  output logic             o_full,
  output logic             o_ready,
  output logic             o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BW-1:0]     mem_r [COL][DEPTH];
  logic [AW-1:0]     wptr_r [COL];
  logic [AW-1:0]     rptr_r [COL];
  logic [CW-1:0]     cnt_r [COL];
  logic [COL*BW-1:0] out_r;
  logic              err_r;

  logic [COL-1:0]    full_s;
  logic [COL-1:0]    empty_s;
  logic [COL-1:0]    wr_acc_s;
  logic              rd_acc_s;
  logic              err_set_s;

  // Per-column full/empty decode from the registered counts only.
  always_comb begin
    full_s  = '0;
    empty_s = '0;
    for (int c = 0; c < COL; c++) begin
      full_s[c]  = (cnt_r[c] == CW'(DEPTH));
      empty_s[c] = (cnt_r[c] == CW'(0));
    end
  end

  assign o_valid  = ~|empty_s;
  assign o_full   = |full_s;
  assign o_ready  = ~o_full;
  assign out      = out_r;
  assign o_err    = err_r;

  // A full column still accepts a write when the same-cycle row read frees a slot.
  assign rd_acc_s  = rd & o_valid;
  assign wr_acc_s  = wr & (~full_s | {COL{rd_acc_s}});
  assign err_set_s = (rd & ~o_valid) | (|(wr & full_s & ~{COL{rd_acc_s}}));

  // Pointers, counts, output row and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < COL; c++) begin
        wptr_r[c] <= '0;
        rptr_r[c] <= '0;
        cnt_r[c]  <= '0;
      end
      out_r <= '0;
      err_r <= 1'b0;
    end else begin
      for (int c = 0; c < COL; c++) begin
        if (wr_acc_s[c]) begin
          wptr_r[c] <= wptr_r[c] + AW'(1);
        end
        if (rd_acc_s) begin
          rptr_r[c]             <= rptr_r[c] + AW'(1);
          out_r[c*BW +: BW]     <= mem_r[c][rptr_r[c]];
        end
        case ({wr_acc_s[c], rd_acc_s})
          2'b10:   cnt_r[c] <= cnt_r[c] + CW'(1);
          2'b01:   cnt_r[c] <= cnt_r[c] - CW'(1);
          default: cnt_r[c] <= cnt_r[c];
        endcase
      end
      err_r <= err_r | err_set_s;
    end
  end

  // Storage array; not cleared by reset, writes blocked while reset is high.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COL; c++) begin
      if (!reset && wr_acc_s[c]) begin
        mem_r[c][wptr_r[c]] <= in[c*BW +: BW];
      end
    end
  end

endmodule

// File: tb/tb_ofifo_collect.sv
// Bench for ofifo_collect: directed scenarios plus random traffic against a per-column queue model.
module tb_ofifo_collect;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_d;
  logic [7:0]   wr;
  logic         rd;
  logic [127:0] out;
  logic         o_valid, o_full, o_ready, o_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]  mq [8][$];
  logic [127:0] e_out;
  logic         e_err;

  ofifo_collect dut (
    .clk(clk), .reset(reset), .in(in_d), .wr(wr), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] row(input logic [15:0] v);
    return {8{v}};
  endfunction

  function automatic logic model_valid();
    for (int c = 0; c < 8; c++) if (mq[c].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_full();
    for (int c = 0; c < 8; c++) if (mq[c].size() == 64) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle, advance the model, then compare every output after the edge.
  task automatic cycle(input logic r, input logic [7:0] w, input logic rr, input logic [127:0] d);
    logic v, racc, full;
    reset = r; wr = w; rd = rr; in_d = d;
    v = model_valid();
    if (r) begin
      for (int c = 0; c < 8; c++) mq[c].delete();
      e_out = '0;
      e_err = 1'b0;
    end else begin
      racc = rr && v;
      if (rr && !v) e_err = 1'b1;
      for (int c = 0; c < 8; c++) begin
        full = (mq[c].size() == 64);
        if (w[c] && full && !racc) e_err = 1'b1;
        if (racc) e_out[c*16 +: 16] = mq[c].pop_front();
        if (w[c] && (!full || racc)) mq[c].push_back(d[c*16 +: 16]);
      end
    end
    @(posedge clk);
    #1;
    chk_eq("out", out, e_out);
    chk_eq("o_valid", 128'(o_valid), 128'(model_valid()));
    chk_eq("o_full", 128'(o_full), 128'(model_full()));
    chk_eq("o_ready", 128'(o_ready), 128'(!model_full()));
    chk_eq("o_err", 128'(o_err), 128'(e_err));
  endtask

  initial begin
    logic [127:0] d;
    logic [7:0]   w;
    e_out = '0; e_err = 1'b0;
    reset = 1'b1; wr = 8'h00; rd = 1'b0; in_d = '0;
    @(posedge clk); #1;
    cycle(1'b1, 8'hFF, 1'b1, row(16'hFFFF));
    chk_eq("rst_out", out, 128'h0);
    chk_eq("rst_ready", 128'(o_ready), 128'h1);
    chk_eq("rst_valid", 128'(o_valid), 128'h0);

    // Staggered fill: column c written in cycle c.
    for (int c = 0; c < 8; c++) begin
      d = '0;
      d[c*16 +: 16] = 16'h0100 + 16'(c);
      cycle(1'b0, 8'(1 << c), 1'b0, d);
      if (c == 6) chk_eq("stag_not_valid", 128'(o_valid), 128'h0);
    end
    chk_eq("stag_valid", 128'(o_valid), 128'h1);
    cycle(1'b0, 8'h00, 1'b1, '0);
    chk_eq("stag_row", out, {16'h0107, 16'h0106, 16'h0105, 16'h0104,
                             16'h0103, 16'h0102, 16'h0101, 16'h0100});
    chk_eq("stag_empty", 128'(o_valid), 128'h0);

    // Fill to full, drain, then traffic across the pointer wrap.
    for (int i = 0; i < 64; i++) cycle(1'b0, 8'hFF, 1'b0, row(16'(i)));
    chk_eq("fill_full", 128'(o_full), 128'h1);
    chk_eq("fill_ready", 128'(o_ready), 128'h0);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 8'h00, 1'b1, '0);
      chk_eq("drain_out", out, row(16'(i)));
    end
    for (int j = 0; j < 10; j++) begin
      cycle(1'b0, 8'hFF, 1'b0, row(16'(64 + j)));
      cycle(1'b0, 8'h00, 1'b1, '0);
      chk_eq("wrap_out", out, row(16'(64 + j)));
    end

    // Overflow on column 3: with a same-cycle read, then without.
    cycle(1'b1, 8'h00, 1'b0, '0);
    for (int i = 0; i < 64; i++) cycle(1'b0, 8'hFF, 1'b0, row(16'(i)));
    cycle(1'b0, 8'h08, 1'b1, row(16'hAAAA));
    chk_eq("ovf_rd_out", out, row(16'h0000));
    chk_eq("ovf_rd_err", 128'(o_err), 128'h0);
    chk_eq("ovf_rd_full", 128'(o_full), 128'h1);
    cycle(1'b0, 8'h08, 1'b0, row(16'hBBBB));
    chk_eq("ovf_err", 128'(o_err), 128'h1);
    for (int i = 0; i < 63; i++) cycle(1'b0, 8'h00, 1'b1, '0);
    chk_eq("ovf_col3_tail", 128'(out[63:48]), 128'(16'd63));

    // Underflow: column 5 empty while the others hold data.
    cycle(1'b1, 8'h00, 1'b0, '0);
    cycle(1'b0, 8'hFF, 1'b0, row(16'h1234));
    cycle(1'b0, 8'h00, 1'b1, '0);
    cycle(1'b0, 8'hDF, 1'b0, row(16'h5555));
    cycle(1'b0, 8'hDF, 1'b0, row(16'h6666));
    cycle(1'b0, 8'h00, 1'b1, '0);
    chk_eq("udf_out", out, row(16'h1234));
    chk_eq("udf_err", 128'(o_err), 128'h1);
    cycle(1'b0, 8'h20, 1'b0, row(16'h7777));
    cycle(1'b0, 8'h00, 1'b1, '0);
    chk_eq("udf_nopop", out, {16'h5555, 16'h5555, 16'h7777, 16'h5555,
                              16'h5555, 16'h5555, 16'h5555, 16'h5555});

    // Reset mid-stream with queued data and a raised error.
    cycle(1'b1, 8'h00, 1'b0, '0);
    cycle(1'b0, 8'h00, 1'b1, '0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'hFF, 1'b0, row(16'(16'h0200 + i)));
    chk_eq("mid_err_before", 128'(o_err), 128'h1);
    cycle(1'b1, 8'hFF, 1'b1, row(16'hDEAD));
    chk_eq("mid_out", out, 128'h0);
    chk_eq("mid_valid", 128'(o_valid), 128'h0);
    chk_eq("mid_err", 128'(o_err), 128'h0);
    cycle(1'b0, 8'hFF, 1'b0, row(16'hC0DE));
    cycle(1'b0, 8'h00, 1'b1, '0);
    chk_eq("mid_first_row", out, row(16'hC0DE));

    // Random traffic, write-biased so columns reach full.
    for (int n = 0; n < 10000; n++) begin
      w = '0;
      for (int c = 0; c < 8; c++) w[c] = ($urandom_range(0, 99) < 60);
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle(($urandom_range(0, 1999) == 0), w, ($urandom_range(0, 99) < 40), d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ofifo_collect.md
OFIFO_COLLECT -- requirements
Module: ofifo_collect

Interface
REQ-001 col, 8, number of independent column queues (one per array column).
REQ-002 bw, 16, data width per column entry.
REQ-003 depth, 64, entries per column queue; power of two, >= 2.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in  input  col*bw  column data; column c occupies bits [c*bw +: bw].
REQ-007 wr  input  col  per-column write strobe; bit c pushes the column-c slice of in.
REQ-008 rd  input  1  row read request; pops one entry from every column.
REQ-009 out  output  col*bw  registered row output; column c in bits [c*bw +: bw].
REQ-010 o_valid  output  1  every column holds at least one entry.
REQ-011 o_full  output  1  at least one column holds depth entries.
REQ-012 o_ready  output  1  no column is full; equals !o_full.
REQ-013 o_err  output  1  sticky protocol-error flag.

Function
REQ-014 Each column SHALL be an independent circular queue with its own write pointer, read pointer and occupancy count (log2(depth)+1 bits).
REQ-015 Pointers SHALL wrap from depth-1 to 0 with no lost or duplicated entries.
REQ-016 Each column SHALL return data in the order it was written.
REQ-017 A row read is accepted when rd=1 and o_valid=1 in the same cycle.
REQ-018 On an accepted read, every column SHALL pop its head entry in the same cycle.
REQ-019 On an accepted read, the popped row SHALL appear on out on the next rising edge (1-cycle latency).
REQ-020 out SHALL hold its last value in any cycle without an accepted read.
REQ-021 A rd with o_valid=0 SHALL be ignored: no pop, out unchanged, o_err set.
REQ-022 A write to column c is accepted when wr[c]=1 and the column is not full, or when it is full and a row read is accepted in the same cycle.
REQ-023 An accepted write SHALL store in[c*bw +: bw] at the column-c write pointer.
REQ-024 A write to a full column with no accepted read SHALL be dropped, leave that column unchanged, and set o_err.
REQ-025 Writes to other columns in the same cycle SHALL still be accepted normally.
REQ-026 Simultaneous accepted write and read on one column SHALL leave its count unchanged and advance both pointers.
REQ-027 A write to an empty column SHALL NOT be readable in the same cycle; o_valid reflects it from the next cycle.
REQ-028 o_valid, o_full and o_ready SHALL be combinational functions of the registered column counts only.
REQ-029 o_err SHALL be cleared only by reset and is otherwise set-only.
REQ-030 Different columns may fill at different rates; o_valid SHALL wait for the slowest column.

Reset
REQ-031 While reset=1, all pointers and counts SHALL be 0 and out SHALL be 0.
REQ-032 While reset=1, o_err SHALL be 0, o_valid 0, o_full 0 and o_ready 1.
REQ-033 While reset=1, wr and rd SHALL be ignored.
REQ-034 Reset asserted mid-operation SHALL discard all stored entries on that edge.
REQ-035 Storage array contents need not be cleared by reset.

Verification
REQ-036 Staggered fill: col=8; write column c with value 16'h0100+c, starting at cycle c (one write per column, cycles 0..7) -> o_valid first =1 in cycle 8; rd in cycle 8 -> out = {16'h0107,...,16'h0100} at the next edge; o_valid then 0.
REQ-037 Fill and wrap: write 64 entries 0..63 to all columns -> o_full=1, o_ready=0; 64 reads -> out steps 0..63 in order; then 10 more writes and reads -> values correct across the pointer wrap.
REQ-038 Overflow: column 3 full, wr=8'h08, rd=0 -> column 3 unchanged, o_err=1; repeat with rd=1 and o_valid=1 -> write accepted, count stays 64, o_err not newly set.
REQ-039 Underflow: column 5 empty, others hold data, rd=1 -> out unchanged, no column pops, o_err=1.
REQ-040 Reset mid-stream: 20 entries queued, o_err=1, reset pulsed for 1 cycle -> out=0, o_valid=0, o_err=0; first row written afterwards reads back correctly.
REQ-041 Random: random wr/rd for 10k cycles against a per-column queue model -> out, o_valid, o_full and o_err match the model every cycle.
